// File: rtl/rca_pkg.sv
// Shared types for the chunk-serial ripple-carry sequencer: slice width and FSM state encoding.
package rca_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rca_seq_state_e;

endpackage

// File: rtl/rca_chunk_serial_sequencer.sv
// Feeds a WIDTH-bit add to an external 3-bit slice adder LSB slice first and
// returns the registered full sum and final carry over a valid/ready handshake.
module rca_chunk_serial_sequencer
  import rca_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_cin,
  output logic [SLICE_W-1:0]   slice_a,
  output logic [SLICE_W-1:0]   slice_b,
  output logic                 slice_cin,
  input  logic [SLICE_W-1:0]   slice_sum,
  input  logic [SLICE_W-1:0]   slice_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_cout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH <= 0) begin : g_width_chk
      $error("rca_chunk_serial_sequencer: WIDTH must be a positive multiple of 3");
    end
  endgenerate

  rca_seq_state_e      state_q, state_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic                carry_q, carry_d;
  logic [WIDTH-1:0]    a_q,     a_d;
  logic [WIDTH-1:0]    b_q,     b_d;
  logic [WIDTH-1:0]    sum_q,   sum_d;
  logic                cout_q,  cout_d;
  int                  off;

  // Only the top bit of the slice carry chain matters; the lower taps are intentionally dropped.
  logic                unused_cout_bits;
  assign unused_cout_bits = ^slice_cout[SLICE_W-2:0];

  assign off       = SLICE_W * int'(idx_q);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

  // Slice drive is decoded from registers only, keeping slice_sum out of this path.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state_q == RUN) begin
      slice_a   = a_q[off +: SLICE_W];
      slice_b   = b_q[off +: SLICE_W];
      slice_cin = carry_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[off +: SLICE_W] = slice_sum;
        carry_d               = slice_cout[SLICE_W-1];
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout[SLICE_W-1];
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_rca_chunk_serial_sequencer.sv
// Bench for rca_chunk_serial_sequencer (WIDTH=12) with a behavioural 3-bit slice adder
// and an arithmetic reference model (a+b+cin).
module tb_rca_chunk_serial_sequencer;

  localparam int WIDTH  = 12;
  localparam int NSLICE = WIDTH / 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [2:0]       slice_a;
  logic [2:0]       slice_b;
  logic             slice_cin;
  logic [2:0]       slice_sum;
  logic [2:0]       slice_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  int total = 0;
  int bad   = 0;

  rca_chunk_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  // Behavioural slice adder: plain 3-bit add, carry chain exposed per bit.
  always_comb begin
    logic [3:0] lo;
    logic [2:0] t;
    slice_cout = '0;
    t = '0;
    for (int i = 0; i < 3; i++) begin
      lo = {1'b0, slice_a & 3'((1 << (i + 1)) - 1)} + {1'b0, slice_b & 3'((1 << (i + 1)) - 1)}
           + {3'b0, slice_cin};
      t[i] = lo[i + 1];
    end
    slice_cout = t;
    slice_sum  = 3'(slice_a + slice_b + {2'b0, slice_cin});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full directed operation: acceptance, per-slice drive, latency, result; leaves DUT in DONE.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input string tag, input bit chk_lat);
    int n;
    int edges;
    int full;
    int mask;
    int cin_k;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~cin;
    edges = 0;
    while (!out_valid && edges < 20) begin
      if (edges < NSLICE) begin
        mask  = (1 << (3 * edges)) - 1;
        cin_k = ((int'(a) & mask) + (int'(b) & mask) + int'(cin)) >> (3 * edges);
        check($sformatf("%s_slice%0d_cin", tag, edges), 32'(slice_cin), 32'(cin_k));
        check($sformatf("%s_slice%0d_a", tag, edges), 32'(slice_a), 32'((int'(a) >> (3 * edges)) & 7));
        check($sformatf("%s_slice%0d_b", tag, edges), 32'(slice_b), 32'((int'(b) >> (3 * edges)) & 7));
      end
      @(negedge clk);
      edges++;
    end
    if (chk_lat) check({tag, "_latency"}, 32'(edges), 32'(NSLICE));
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    full = int'(a) + int'(b) + int'(cin);
    check({tag, "_sum"}, 32'(out_sum), 32'(full & 'hFFF));
    check({tag, "_cout"}, 32'(out_cout), 32'((full >> WIDTH) & 1));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [12:0] expq[$];
    logic [12:0] e;
    logic [WIDTH-1:0] ra, rb;
    logic rc;
    int sent, recvd, cyc, seen_valid;
    bit acc, xfer;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_slices", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_outs", 32'({out_cout, out_sum}), 32'd0);
    check("post_rst_slices", 32'({slice_a, slice_b, slice_cin}), 32'd0);

    run_op(12'hFFF, 12'h001, 1'b0, "ovf", 1'b1);
    check("ovf_sum_const", 32'(out_sum), 32'h000);
    check("ovf_cout_const", 32'(out_cout), 32'd1);
    release_result("ovf");

    run_op(12'h5A5, 12'h2D3, 1'b1, "mix", 1'b1);
    check("mix_sum_const", 32'(out_sum), 32'h879);
    check("mix_cout_const", 32'(out_cout), 32'd0);

    // Backpressure: hold result while a new request is offered.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 12'h123; in_b = 12'h456; in_cin = 1'b1;
      @(negedge clk);
      check($sformatf("bp%0d_sum", i), 32'(out_sum), 32'h879);
      check($sformatf("bp%0d_cout", i), 32'(out_cout), 32'd0);
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_result("bp");
    @(negedge clk);
    check("bp_not_captured", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle.
    in_a = 12'h3C3; in_b = 12'h0F0; in_cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outs", 32'({out_cout, out_sum}), 32'd0);
    check("midrst_slices", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("midrst_no_valid", 32'(seen_valid), 32'd0);
    run_op(12'h007, 12'h001, 1'b0, "after_rst", 1'b1);
    check("after_rst_sum_const", 32'(out_sum), 32'h008);
    release_result("after_rst");

    // Random back-to-back traffic against the arithmetic model.
    sent = 0; recvd = 0; cyc = 0;
    ra = 12'($urandom); rb = 12'($urandom); rc = 1'($urandom);
    in_a = ra; in_b = rb; in_cin = rc; in_valid = 1'b1; out_ready = 1'b1;
    while (recvd < 1000 && cyc < 30000) begin
      out_ready = (recvd < 500) ? 1'b1 : 1'($urandom_range(0, 1));
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        e = (expq.size() > 0) ? expq.pop_front() : 13'h1FFF;
        check($sformatf("rnd%0d", recvd), 32'({out_cout, out_sum}), 32'(e));
        recvd++;
      end
      if (acc) begin
        expq.push_back(13'({1'b0, ra} + {1'b0, rb} + {12'b0, rc}));
        sent++;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        if (sent < 1000) begin
          ra = 12'($urandom); rb = 12'($urandom); rc = 1'($urandom);
          in_a = ra; in_b = rb; in_cin = rc;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rnd_received", 32'(recvd), 32'd1000);
    check("rnd_queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
